multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
Multi-cycle sequencer for the RV32I datapath. It replaces the single-cycle combinational control unit so that the register file, ALU, sign extender and a single unified memory can be reused across several cycles per instruction. It sits beside the datapath top. It drives all datapath select/enable strobes and runs a request/ready handshake with the unified memory. It also keeps a retired-instruction counter and a sticky trap flag.

Parameters:
CNT_WIDTH, 32, width of retired-instruction counter
DATA_WIDTH, 32, datapath width (informational; instruction fields only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
run  in  1  leave IDLE and start fetching; sampled in IDLE only
instr  in  32  latched instruction register contents (valid after FETCH completes)
eq  in  1  ALU zero/equal flag from datapath, valid in BRANCH state
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory access request; held until mem_ready
mem_we  out  1  write qualifier for mem_req
adr_src  out  1  0 = PC drives address, 1 = ALU result register
ir_write  out  1  load instruction register
pc_write  out  1  load PC from result mux
reg_write  out  1  register file write enable
alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1
alu_src_b  out  2  00 rs2, 01 ImmOp, 10 constant 4
alu_ctrl  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL
imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
result_src  out  2  00 ALUOut, 01 mem data, 10 ALU result (direct)
trap  out  1  sticky: illegal opcode seen
instret  out  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset (async, any state, including mid memory request): state = IDLE, instret = 0, trap = 0.
- All strobes are Moore outputs decoded from state. In IDLE and TRAP every output is 0.
- States and transitions:
  - IDLE: if run -> FETCH.
  - FETCH: mem_req = 1, adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu_ctrl = ADD, result_src = 10. Stay while !mem_ready. When mem_ready: ir_write = 1 and pc_write = 1 in that same cycle, -> DECODE.
  - DECODE: alu_src_a = 01, alu_src_b = 01, imm_src = B, ADD (branch target into ALUOut). Next state by opcode:
    - 0000011 -> MEMADR
    - 0100011 -> MEMADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 0110111 -> LUI
    - any other opcode -> TRAP
  - MEMADR: rs1 + imm. imm_src = I for loads, S for stores. -> MEMREAD (load) or MEMWRITE (store).
  - MEMREAD: mem_req = 1, adr_src = 1. Wait for mem_ready, then -> MEMWB.
  - MEMWB: result_src = 01, reg_write = 1 -> FETCH.
  - MEMWRITE: mem_req = 1, mem_we = 1, adr_src = 1. Wait for mem_ready, then -> FETCH.
  - EXEC_R / EXEC_I: alu_ctrl from funct3/funct7[5]. funct7[5] selects SUB only for R-type funct3 = 000. -> ALUWB.
  - ALUWB: result_src = 00, reg_write = 1 -> FETCH.
  - BRANCH: rs1 - rs2, result_src = 00. pc_write = eq for funct3 000 (BEQ), = !eq for funct3 001 (BNE). Any other funct3 -> TRAP. Otherwise -> FETCH.
  - JAL: alu_src_a = 01, alu_src_b = 10, ADD. result_src = 00 (target) for pc_write = 1; oldPC + 4 goes to ALUOut. -> ALUWB.
  - LUI: imm_src = U, alu_src_b = 01, ALU passes imm via ADD with rs1 forced x0 by datapath. -> ALUWB.
  - TRAP: trap = 1, stays until reset.
- instret increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH. It wraps modulo 2^CNT_WIDTH.
- mem_req may be held indefinitely. Address/we selects are stable for the whole request.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum
  - opcode constants
  - alu_ctrl, imm_src, result_src, alu_src_a/b encodings
- One sub-module: alu_decoder (combinational funct3/funct7b5/op -> alu_ctrl), reused by EXEC_R/EXEC_I.

Test Plan:
- Reset with run = 1, mem_ready = 1, instr = addi x1,x0,5 (0x00500093) -> states FETCH, DECODE, EXEC_I, ALUWB, FETCH; reg_write high only in ALUWB; instret = 1.
- lw (0x00002183) with mem_ready low for 3 cycles in MEMREAD -> mem_req/adr_src held 4 cycles, MEMWB one cycle later, instret += 1.
- beq with eq = 1 then eq = 0 -> pc_write = 1 in BRANCH only for the first; both retire.
- sw (0x00312023) -> MEMWRITE asserts mem_req & mem_we until mem_ready; no reg_write at any point.
- Opcode 0x7F -> TRAP after DECODE; trap = 1 sticky, all strobes 0, instret unchanged. Assert rst -> trap = 0, IDLE.
- rst asserted mid-FETCH wait (mem_req = 1) -> mem_req drops asynchronously, state IDLE, instret = 0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer: states, opcodes and
// the select codes it drives into the datapath.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_LUI,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_fsm_alu_decoder.sv
// funct3/funct7[5] to ALU operation; SLTU folds onto SLT and SRA onto SRL
// because the ALU implements neither.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_rtype,
    output logic [2:0] o_alu_ctrl
);

    always_comb begin
        o_alu_ctrl = ALU_ADD;
        case (i_funct3)
            3'b000: o_alu_ctrl = (i_rtype && i_funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: o_alu_ctrl = ALU_SLL;
            3'b010: o_alu_ctrl = ALU_SLT;
            3'b011: o_alu_ctrl = ALU_SLT;
            3'b100: o_alu_ctrl = ALU_XOR;
            3'b101: o_alu_ctrl = ALU_SRL;
            3'b110: o_alu_ctrl = ALU_OR;
            3'b111: o_alu_ctrl = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I datapath: drives the datapath
// strobes per state, handshakes with unified memory, counts retired instructions.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int CNT_WIDTH  = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  eq,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [2:0]            alu_ctrl,
    output logic [2:0]            imm_src,
    output logic [1:0]            result_src,
    output logic                  trap,
    output logic [CNT_WIDTH-1:0]  instret
);

    state_t               r_state;
    state_t               w_next;
    logic                 r_trap;
    logic [CNT_WIDTH-1:0] r_instret;
    logic                 w_retire;
    logic [2:0]           w_alu_dec;
    logic                 w_unused_instr;

    wire logic [6:0] w_opcode = instr[6:0];
    wire logic [2:0] w_funct3 = instr[14:12];

    assign w_unused_instr = ^{instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .i_funct3  (w_funct3),
        .i_funct7b5(instr[30]),
        .i_rtype   (r_state == S_EXEC_R),
        .o_alu_ctrl(w_alu_dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_trap    <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP)
                r_trap <= 1'b1;
            if (w_retire)
                r_instret <= r_instret + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_ctrl   = ALU_ADD;
        imm_src    = IMM_I;
        result_src = RES_ALUOUT;
        case (r_state)
            S_IDLE: if (run) w_next = S_FETCH;
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is computed speculatively here into ALUOut
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_B;
                case (w_opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXEC_R;
                    OP_ITYPE:          w_next = S_EXEC_I;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_LUI:            w_next = S_LUI;
                    default:           w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = (w_opcode == OP_STORE) ? IMM_S : IMM_I;
                w_next    = (w_opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_ctrl  = w_alu_dec;
                w_next    = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_I;
                alu_ctrl  = w_alu_dec;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_ctrl  = ALU_SUB;
                case (w_funct3)
                    3'b000: begin pc_write = eq;  w_retire = 1'b1; w_next = S_FETCH; end
                    3'b001: begin pc_write = !eq; w_retire = 1'b1; w_next = S_FETCH; end
                    default: w_next = S_TRAP;
                endcase
            end
            S_JAL: begin
                // PC takes the DECODE target from ALUOut while oldPC+4 lands in ALUOut
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
                w_next    = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_U;
                w_next    = S_ALUWB;
            end
            S_TRAP: w_next = S_TRAP;
            default: w_next = S_IDLE;
        endcase
    end

    assign trap    = r_trap;
    assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed + randomized bench for multicycle_ctrl_fsm; expected strobes come from
// a per-instruction phase plan built from the instruction-class rules.
module tb_multicycle_ctrl_fsm;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, run, eq, mem_ready;
    logic [31:0]   instr;
    logic          mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, trap;
    logic [1:0]    alu_src_a, alu_src_b, result_src;
    logic [2:0]    alu_ctrl, imm_src;
    logic [CW-1:0] instret;

    multicycle_ctrl_fsm #(.CNT_WIDTH(CW), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .run(run), .instr(instr), .eq(eq), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .imm_src(imm_src),
        .result_src(result_src), .trap(trap), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       req, we, adr, irw, pcw, rw;
        logic [1:0] sa, sb;
        logic [2:0] ac, isrc;
        logic [1:0] rs;
        logic       trp;
    } outs_t;

    typedef struct {
        logic  mr;
        logic  eqv;
        outs_t e;
        string tag;
    } step_t;

    outs_t         obs;
    step_t         q[$];
    int            nchk = 0;
    int            nfail = 0;
    logic [CW-1:0] m_instret = '0;

    // ALU operation implied by funct3 (ADD,SLL,SLT,SLTU->SLT,XOR,SRL,OR,AND)
    logic [2:0] f3_alu [8] = '{3'd0, 3'd6, 3'd5, 3'd5, 3'd4, 3'd7, 3'd3, 3'd2};
    logic [6:0] legal_ops [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                  7'b1100011, 7'b1101111, 7'b0110111};

    assign obs = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, alu_ctrl, imm_src, result_src, trap};

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void check_o(input outs_t exp, input string tag);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endfunction

    function automatic void check_cnt(input logic [CW-1:0] exp, input string tag);
        nchk++;
        assert (instret === exp) else begin
            nfail++;
            $error("FAIL %s: observed instret %0d expected %0d", tag, instret, exp);
        end
    endfunction

    function automatic void push(input logic mr, input logic ev, input outs_t e, input string t);
        step_t s;
        s.mr = mr; s.eqv = ev; s.e = e; s.tag = t;
        q.push_back(s);
    endfunction

    function automatic void plan(input logic [31:0] ins, input logic eqv, input int fw,
                                 input int mw, output bit retires);
        outs_t      e, tv;
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        bit         traps = 1'b0;
        retires = 1'b0;
        tv = '0; tv.trp = 1'b1;
        e = '0; e.req = 1'b1; e.sb = 2'b10; e.rs = 2'b10;
        for (int i = 0; i < fw; i++) push(1'b0, rbit(), e, "fetch_wait");
        e.irw = 1'b1; e.pcw = 1'b1;
        push(1'b1, rbit(), e, "fetch_done");
        e = '0; e.sa = 2'b01; e.sb = 2'b01; e.isrc = 3'd2;
        push(rbit(), rbit(), e, "decode");
        if (op == 7'b0000011 || op == 7'b0100011) begin
            e = '0; e.sa = 2'b10; e.sb = 2'b01; e.isrc = (op == 7'b0100011) ? 3'd1 : 3'd0;
            push(rbit(), rbit(), e, "memadr");
            e = '0; e.req = 1'b1; e.adr = 1'b1; e.we = (op == 7'b0100011);
            for (int i = 0; i < mw; i++) push(1'b0, rbit(), e, "mem_wait");
            push(1'b1, rbit(), e, "mem_done");
            if (op == 7'b0000011) begin
                e = '0; e.rs = 2'b01; e.rw = 1'b1;
                push(rbit(), rbit(), e, "memwb");
            end
            retires = 1'b1;
        end else if (op == 7'b0110011 || op == 7'b0010011) begin
            e = '0; e.sa = 2'b10;
            if (op == 7'b0110011) begin
                e.sb = 2'b00;
                e.ac = (f3 == 3'd0 && ins[30]) ? 3'd1 : f3_alu[f3];
            end else begin
                e.sb = 2'b01;
                e.ac = f3_alu[f3];
            end
            push(rbit(), rbit(), e, "exec");
            e = '0; e.rw = 1'b1;
            push(rbit(), rbit(), e, "aluwb");
            retires = 1'b1;
        end else if (op == 7'b1100011) begin
            e = '0; e.sa = 2'b10; e.sb = 2'b00; e.ac = 3'd1;
            if (f3 == 3'd0) e.pcw = eqv;
            else if (f3 == 3'd1) e.pcw = !eqv;
            push(rbit(), eqv, e, "branch");
            if (f3 > 3'd1) traps = 1'b1;
            else retires = 1'b1;
        end else if (op == 7'b1101111 || op == 7'b0110111) begin
            e = '0;
            if (op == 7'b1101111) begin
                e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1;
            end else begin
                e.sa = 2'b10; e.sb = 2'b01; e.isrc = 3'd4;
            end
            push(rbit(), rbit(), e, "jal_lui");
            e = '0; e.rw = 1'b1;
            push(rbit(), rbit(), e, "aluwb");
            retires = 1'b1;
        end else begin
            traps = 1'b1;
        end
        if (traps)
            for (int i = 0; i < 4; i++) push(rbit(), rbit(), tv, "trap_hold");
    endfunction

    task automatic do_instr(input logic [31:0] ins, input logic eqv, input int fw,
                            input int mw, input string name);
        bit ret;
        instr = ins;
        plan(ins, eqv, fw, mw, ret);
        for (int i = 0; i < q.size(); i++) begin
            #1 mem_ready = q[i].mr; eq = q[i].eqv;
            #1 check_o(q[i].e, {name, ":", q[i].tag});
            @(posedge clk);
        end
        q.delete();
        if (ret) m_instret++;
        #1 check_cnt(m_instret, {name, ":instret"});
    endtask

    // Asynchronous reset mid-cycle, then restart into FETCH
    task automatic reset_async(input string tag);
        #3 rst = 1'b1;
        #1 check_o('0, {tag, ":outputs"});
        check_cnt('0, {tag, ":instret"});
        m_instret = '0;
        @(posedge clk);
        #1 rst = 1'b0; run = 1'b1;
        #1 check_o('0, {tag, ":idle"});
        @(posedge clk);
    endtask

    initial begin
        outs_t fe;
        logic [31:0] ins;
        rst = 1'b1; run = 1'b0; eq = 1'b0; mem_ready = 1'b1; instr = 32'h00500093;
        @(posedge clk); @(posedge clk);
        #1 check_o('0, "reset:outputs");
        check_cnt('0, "reset:instret");
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 check_o('0, "idle_no_run");
            @(posedge clk); #1;
        end
        run = 1'b1;
        #1 check_o('0, "idle_run");
        @(posedge clk);

        do_instr(32'h00500093, 1'b0, 0, 0, "addi");
        do_instr(32'h00002183, 1'b0, 1, 3, "lw");
        do_instr(32'h00208463, 1'b1, 0, 0, "beq_taken");
        do_instr(32'h00208463, 1'b0, 0, 0, "beq_not");
        do_instr(32'h00209463, 1'b1, 0, 0, "bne_not");
        do_instr(32'h00312023, 1'b0, 0, 2, "sw");
        do_instr(32'h40208033, 1'b0, 0, 0, "sub");
        do_instr(32'h40008093, 1'b0, 0, 0, "addi_b30");
        do_instr(32'h008000EF, 1'b0, 2, 0, "jal");
        do_instr(32'h123450B7, 1'b0, 0, 0, "lui");

        for (int n = 0; n < 24; n++) begin
            ins = $urandom;
            ins[6:0] = legal_ops[$urandom_range(0, 6)];
            if (ins[6:0] == 7'b1100011) ins[14:12] = {2'b00, rbit()};
            run = rbit();
            do_instr(ins, rbit(), $urandom_range(0, 2), $urandom_range(0, 3), "rand");
        end

        do_instr(32'h0020A463, 1'b0, 0, 0, "branch_f3_bad");
        reset_async("rst_after_trap1");
        do_instr(32'h0000007F, 1'b0, 0, 0, "illegal_7f");
        reset_async("rst_after_trap2");

        do_instr(32'h00500093, 1'b0, 0, 0, "addi2");
        fe = '0; fe.req = 1'b1; fe.sb = 2'b10; fe.rs = 2'b10;
        for (int i = 0; i < 2; i++) begin
            #1 mem_ready = 1'b0;
            #1 check_o(fe, "fetch_hold");
            @(posedge clk); #1;
        end
        reset_async("rst_mid_fetch");
        do_instr(32'h00002183, 1'b0, 0, 1, "lw_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
